// File: rtl/smult_accum.sv
// Sums TERMS signed products from a 2-cycle upstream multiplier, adds a scaled
// offset, arithmetic-shifts right by SHIFT and saturates to an N-bit result.
module smult_accum #(
  parameter int N     = 8,
  parameter int TERMS = 2,
  parameter int SHIFT = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic signed [2*N-1:0] prod_in,
  input  logic signed [N-1:0]   offset,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  out_valid,
  output logic signed [N-1:0]   result
);

  localparam int ACCW = 2*N + 4;
  // Final sum is formed wider than the accumulator so the shifted offset never wraps.
  localparam int TW   = ACCW + N;
  localparam int CW   = $clog2(TERMS + 1);
  localparam logic signed [TW-1:0] MAX_V = TW'((1 <<< (N-1)) - 1);
  localparam logic signed [TW-1:0] MIN_V = -MAX_V - 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [CW-1:0]          icnt_q, icnt_d;
  logic [CW-1:0]          pcnt_q, pcnt_d;
  logic [1:0]             vld_pipe_q, vld_pipe_d;
  logic signed [N-1:0]    result_q, result_d;
  logic                   out_valid_q, out_valid_d;

  logic                   accept, dvld, final_term;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [TW-1:0]   total, shifted;

  always_comb begin
    busy       = (icnt_q == CW'(TERMS)) || (state_q == DONE);
    accept     = issue && !busy;
    dvld       = vld_pipe_q[1];
    final_term = dvld && (pcnt_q == CW'(TERMS - 1));
    prod_ext   = {{4{prod_in[2*N-1]}}, prod_in};
    total      = {{N{acc_q[ACCW-1]}}, acc_q}
               + {{(TW-2*N){prod_in[2*N-1]}}, prod_in}
               + ({{(TW-N){offset[N-1]}}, offset} <<< SHIFT);
    shifted    = total >>> SHIFT;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    icnt_d      = icnt_q + CW'(accept);
    pcnt_d      = pcnt_q;
    vld_pipe_d  = {vld_pipe_q[0], accept};
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (accept) state_d = ACCUM;
      ACCUM: begin
        if (final_term) begin
          if (shifted > MAX_V)      result_d = {1'b0, {(N-1){1'b1}}};
          else if (shifted < MIN_V) result_d = {1'b1, {(N-1){1'b0}}};
          else                      result_d = shifted[N-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (dvld) begin
          acc_d  = acc_q + prod_ext;
          pcnt_d = pcnt_q + CW'(1);
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        acc_d       = '0;
        icnt_d      = '0;
        pcnt_d      = '0;
        vld_pipe_d  = '0;
        out_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      icnt_q      <= '0;
      pcnt_q      <= '0;
      vld_pipe_q  <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      icnt_q      <= icnt_d;
      pcnt_q      <= pcnt_d;
      vld_pipe_q  <= vld_pipe_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_smult_accum.sv
// Self-checking bench for smult_accum (N=8, TERMS=2, SHIFT=7): directed table,
// hold/backpressure, reset and randomized transactions against an arithmetic model.
module tb_smult_accum;
  localparam int N = 8, TERMS = 2, SHIFT = 7;

  logic                 clk = 1'b0;
  logic                 reset, issue, out_ready;
  logic signed [15:0]   prod_in;
  logic signed [7:0]    offset;
  logic                 busy, out_valid;
  logic signed [7:0]    result;

  int pass_cnt = 0;
  int total_cnt = 0;

  smult_accum #(.N(N), .TERMS(TERMS), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .issue(issue), .prod_in(prod_in), .offset(offset),
    .out_ready(out_ready), .busy(busy), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint p0;
    longint p1;
    longint off;
    longint exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: exact sum, floor divide by 2^SHIFT, clamp to the N-bit signed range.
  function automatic longint ref_result(input longint p0, input longint p1, input longint off);
    longint t, s;
    t = p0 + p1 + off * (64'sd1 <<< SHIFT);
    s = t >>> SHIFT;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  // Issues at cycle 0 and 1+g; products return 2 cycles after each issue.
  task automatic run_txn(input string nm, input longint p0, input longint p1,
                         input longint off, input longint exp, input int g,
                         input int hold, input bit rst_done);
    int f;
    f = 3 + g;
    for (int c = 0; c <= f; c++) begin
      issue     = (c == 0) || (c == 1 + g);
      prod_in   = (c == 2) ? 16'(p0) : (c == f) ? 16'(p1) : 16'($urandom);
      offset    = (c == f) ? 8'(off) : 8'($urandom);
      out_ready = 1'($urandom);
      chk({nm, ".busy"}, longint'(busy), longint'(c >= 2 + g));
      chk({nm, ".vld_early"}, longint'(out_valid), 0);
      tick();
    end
    issue     = 1'b1;
    prod_in   = 16'($urandom);
    offset    = 8'($urandom);
    out_ready = (hold == 0) && !rst_done;
    chk({nm, ".out_valid"}, longint'(out_valid), 1);
    chk({nm, ".result"}, longint'(result), exp);
    chk({nm, ".busy_done"}, longint'(busy), 1);
    if (rst_done) begin
      #2 reset = 1'b1;
      #1;
      chk({nm, ".rst_vld"}, longint'(out_valid), 0);
      chk({nm, ".rst_busy"}, longint'(busy), 0);
      chk({nm, ".rst_res"}, longint'(result), 0);
      issue = 1'b0;
      tick();
      reset = 1'b0;
      return;
    end
    for (int h = 1; h <= hold; h++) begin
      tick();
      prod_in = 16'($urandom);
      chk({nm, ".hold_vld"}, longint'(out_valid), 1);
      chk({nm, ".hold_res"}, longint'(result), exp);
      chk({nm, ".hold_busy"}, longint'(busy), 1);
      out_ready = (h == hold);
    end
    tick();
    issue     = 1'b0;
    out_ready = 1'b0;
    chk({nm, ".post_vld"}, longint'(out_valid), 0);
    chk({nm, ".post_busy"}, longint'(busy), 0);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{4096, 4096, 10, 74};
    vecs[1] = '{16129, 16129, 0, 127};
    vecs[2] = '{-16256, -16256, 0, -128};
    vecs[3] = '{100, 0, 0, 0};
    vecs[4] = '{-100, 0, 0, -1};

    reset = 1'b1; issue = 1'b0; out_ready = 1'b0; prod_in = '0; offset = '0;
    tick(); tick();
    chk("reset.out_valid", longint'(out_valid), 0);
    chk("reset.busy", longint'(busy), 0);
    chk("reset.result", longint'(result), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].p0, vecs[i].p1, vecs[i].off, vecs[i].exp, 0, 0, 0);

    // Backpressure with issue pulsed every cycle while held.
    run_txn("hold5", 4096, 4096, 10, 74, 0, 5, 0);
    run_txn("after_hold", 1000, -3000, 5, ref_result(1000, -3000, 5), 0, 0, 0);

    // Gaps between issues.
    run_txn("gap3", 2560, 1280, -2, ref_result(2560, 1280, -2), 3, 1, 0);

    // Reset between first and second issue; stale products must be ignored.
    issue = 1'b1; prod_in = 16'($urandom);
    tick();
    issue = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_accum.out_valid", longint'(out_valid), 0);
    chk("rst_accum.busy", longint'(busy), 0);
    chk("rst_accum.result", longint'(result), 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      prod_in = 16'sd16000; offset = 8'sd100; out_ready = 1'b1;
      chk("rst_accum.quiet_vld", longint'(out_valid), 0);
      tick();
    end
    out_ready = 1'b0;
    run_txn("post_rst", 4096, 4096, 10, 74, 0, 0, 0);

    // Reset while the result is waiting in DONE.
    run_txn("rst_done", 3000, 2000, 1, ref_result(3000, 2000, 1), 1, 0, 1);
    for (int c = 0; c < 4; c++) begin
      prod_in = 16'($urandom);
      chk("rst_done.quiet_vld", longint'(out_valid), 0);
      tick();
    end
    run_txn("post_rst2", -5000, 1234, -7, ref_result(-5000, 1234, -7), 0, 0, 0);

    for (int k = 0; k < 25; k++) begin
      shortint rp0, rp1;
      byte     roff;
      rp0  = shortint'($urandom);
      rp1  = shortint'($urandom);
      roff = byte'($urandom);
      run_txn($sformatf("rand%0d", k), rp0, rp1, roff, ref_result(rp0, rp1, roff),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/smult_accum.md
SMULT_ACCUM -- requirements
Module: smult_accum

Interface
REQ-001 Parameter N, default 8: operand width of the upstream signed multiplier; product width 2N; result width N.
REQ-002 Parameter TERMS, default 2: products summed per result; legal range 1..8.
REQ-003 Parameter SHIFT, default 7: fixed-point arithmetic right shift applied to the sum; legal range 0..2N-2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 issue  input  1  high in the cycle operands are presented to the upstream multiplier.
REQ-007 prod_in  input  2N  signed product from the multiplier, valid exactly 2 cycles after the matching accepted issue.
REQ-008 offset  input  N  signed offset, sampled only in the final-term cycle.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 busy  output  1  high: issue is ignored.
REQ-011 out_valid  output  1  result valid and held.
REQ-012 result  output  N  signed, saturated result.

Function
REQ-013 Accepted issue = issue && !busy; accepted issues increment an issue counter (0..TERMS).
REQ-014 busy SHALL be high when issue counter == TERMS or state == DONE, otherwise low.
REQ-015 A 2-stage valid shift register SHALL delay each accepted issue by 2 cycles, marking prod_in valid, matching multiplier latency.
REQ-016 Accumulator width SHALL be ACCW = 2N+4; prod_in sign-extended to ACCW before addition; no internal overflow for legal parameters.
REQ-017 States: IDLE (no terms issued), ACCUM (>=1 term issued, result pending), DONE (out_valid high).
REQ-018 IDLE -> ACCUM on an accepted issue; ACCUM -> DONE at the edge ending the cycle in which the TERMS-th delayed valid occurs; DONE -> IDLE on out_valid && out_ready.
REQ-019 Non-final delayed valid: acc <= acc + sext(prod_in); product counter increments.
REQ-020 Final delayed valid: total = acc + sext(prod_in) + (sext(offset) << SHIFT); shifted = total >>> SHIFT (floor, no rounding); result register loaded with shifted saturated to [-2^(N-1), 2^(N-1)-1].
REQ-021 out_valid SHALL rise the cycle after the final-term cycle; latency first issue -> out_valid = TERMS+2 cycles with back-to-back issues.
REQ-022 result and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 Handshake edge SHALL clear acc, both counters and valid pipe, deassert out_valid; issue in the handshake cycle is ignored (busy high); busy low the following cycle.
REQ-024 Gaps between issues are legal; accumulation waits for delayed valids without timeout.
REQ-025 prod_in SHALL be ignored whenever its delayed valid is low.

Reset
REQ-026 reset high SHALL immediately force state IDLE, acc 0, counters 0, valid pipe 0, out_valid 0, result 0, busy 0, independent of clk.
REQ-027 Reset mid-ACCUM or mid-DONE SHALL discard all in-flight terms; products arriving after reset release without a post-reset accepted issue SHALL be ignored.

Verification (N=8, TERMS=2, SHIFT=7)
REQ-028 Issue cycles 0,1; prod_in 4096 at cycles 2,3; offset 10 -> out_valid cycle 4, result 74, busy high cycles 2-4.
REQ-029 Products 16129, 16129, offset 0 -> result 127 (saturated); products -16256, -16256 -> result -128.
REQ-030 Products 100, 0 -> result 0; products -100, 0 -> result -1 (floor).
REQ-031 out_ready low 5 cycles after out_valid, issue pulsed each cycle -> result held, busy high, issues ignored; out_ready high -> out_valid low next cycle, next issue accepted.
REQ-032 Reset asserted between first and second issue -> out_valid never asserts; fresh 2-term sequence afterwards produces the correct result unaffected by stale products.
